nabp_mapper: RTL and testbench

Sequencer that drives the mapper LUT and turns its fixed-point accumulator constants into line-buffer addresses. For each projection angle it steps `mp_line_cnt` over every PE line and waits out the LUT's two-cycle latency. It then accumulates `mp_accu_init + k·mp_accu_base` to emit `MAP_LEN` addresses per line through a valid/ready stream. It sits between the angle scheduler and the line buffer.

---
 rtl/nabp_mapper.sv | 128 ++++++++++++
 tb/tb_nabp_mapper.sv | 130 +++++++++++++
 2 files changed

// File: rtl/nabp_mapper.sv
// Mapper sequencer: walks PE lines for an angle, waits out LUT latency, streams accumulated addresses.
// Optional build macro NABP_MAPPER_ROUND_EN selects round-half-up instead of floor for the integer part.
module nabp_mapper #(
  parameter int kAngleLength   = 9,
  parameter int kPEWidthLength = 4,
  parameter int NUM_LINES      = 16,
  parameter int MAP_LEN        = 256,
  parameter int ADDR_W         = 8,
  parameter int ACCU_W         = 20,
  parameter int FRAC_W         = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [kAngleLength-1:0]   angle,
  output logic                      busy,
  output logic                      done,
  output logic [kAngleLength-1:0]   mp_angle,
  output logic [kPEWidthLength-1:0] mp_line_cnt,
  input  logic [ACCU_W-1:0]         mp_accu_init,
  input  logic [ACCU_W-1:0]         mp_accu_base,
  output logic                      addr_valid,
  input  logic                      addr_ready,
  output logic [ADDR_W-1:0]         addr,
  output logic [kPEWidthLength-1:0] addr_line,
  output logic                      addr_last,
  output logic                      addr_oob
);

  typedef enum logic [1:0] {IDLE, LOOKUP, MAP, DONE} state_t;

  localparam logic [ADDR_W-1:0]         KLAST = ADDR_W'(MAP_LEN - 1);
  localparam logic [kPEWidthLength-1:0] LLAST = kPEWidthLength'(NUM_LINES - 1);
  localparam logic signed [ACCU_W:0]    LIM   = (ACCU_W+1)'(MAP_LEN - 1);
  localparam logic signed [ACCU_W:0]    HALF  = (ACCU_W+1)'(2 ** (FRAC_W - 1));

  state_t                    state, state_n;
  logic [1:0]                wcnt;
  logic [ADDR_W-1:0]         k;
  logic signed [ACCU_W-1:0]  accu, base, accu_n;
  logic                      oob_r, xfer, beat_last, capture;
  logic [ADDR_W:0]           m_init, m_next;

  // Returns {oob, clamped address} for an accumulator value.
  function automatic logic [ADDR_W:0] map_f(input logic signed [ACCU_W-1:0] a);
    logic signed [ACCU_W:0] s;
    s = {a[ACCU_W-1], a};
`ifdef NABP_MAPPER_ROUND_EN
    s = s + HALF;
`endif
    s = s >>> FRAC_W;
    if (s[ACCU_W])   map_f = {1'b1, {ADDR_W{1'b0}}};
    else if (s > LIM) map_f = {1'b1, KLAST};
    else              map_f = {1'b0, s[ADDR_W-1:0]};
  endfunction

  always_comb begin
    xfer      = (state == MAP) && addr_ready;
    beat_last = (k == KLAST);
    accu_n    = accu + base;
    m_init    = map_f(mp_accu_init);
    m_next    = map_f(accu_n);
    capture   = 1'b0;
    state_n   = state;
    case (state)
      IDLE:    if (start) state_n = LOOKUP;
      LOOKUP:  if (wcnt == 2'd1) begin
                 capture = 1'b1;
                 state_n = MAP;
               end
      MAP:     if (xfer && beat_last) state_n = (mp_line_cnt == LLAST) ? DONE : LOOKUP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mp_angle    <= '0;
      mp_line_cnt <= '0;
      wcnt        <= '0;
      k           <= '0;
      accu        <= '0;
      base        <= '0;
      addr        <= '0;
      oob_r       <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
      case (state)
        IDLE: if (start) begin
          mp_angle    <= angle;
          mp_line_cnt <= '0;
          wcnt        <= 2'd2;
        end
        LOOKUP: begin
          wcnt <= wcnt - 2'd1;
          if (capture) begin
            accu          <= mp_accu_init;
            base          <= mp_accu_base;
            k             <= '0;
            {oob_r, addr} <= m_init;
          end
        end
        MAP: if (xfer) begin
          accu          <= accu_n;
          k             <= k + 1'b1;
          {oob_r, addr} <= m_next;
          if (beat_last && (mp_line_cnt != LLAST)) begin
            mp_line_cnt <= mp_line_cnt + 1'b1;
            wcnt        <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign addr_valid = (state == MAP);
  assign addr_last  = addr_valid && beat_last;
  assign addr_oob   = addr_valid && oob_r;
  assign addr_line  = mp_line_cnt;

endmodule

// File: tb/tb_nabp_mapper.sv
// Directed bench for nabp_mapper with a 2-line, 4-beat configuration and a constant LUT.
module tb_nabp_mapper;
  localparam int AL = 9, PL = 4, NL = 2, ML = 4, AW = 8, CW = 20, FW = 8;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, addr_ready = 1'b1;
  logic [AL-1:0] angle = '0;
  logic [CW-1:0] mp_accu_init = '0, mp_accu_base = '0;
  logic          busy, done, addr_valid, addr_last, addr_oob;
  logic [AL-1:0] mp_angle;
  logic [PL-1:0] mp_line_cnt, addr_line;
  logic [AW-1:0] addr;

  int tests = 0, fails = 0;
  logic [AW-1:0] ea [4];
  logic [3:0]    eo;

  nabp_mapper #(.kAngleLength(AL), .kPEWidthLength(PL), .NUM_LINES(NL), .MAP_LEN(ML),
                .ADDR_W(AW), .ACCU_W(CW), .FRAC_W(FW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .angle(angle), .busy(busy), .done(done),
    .mp_angle(mp_angle), .mp_line_cnt(mp_line_cnt), .mp_accu_init(mp_accu_init),
    .mp_accu_base(mp_accu_base), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .addr_line(addr_line), .addr_last(addr_last), .addr_oob(addr_oob));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [CW-1:0] init, input logic [CW-1:0] bas,
                         input int a0, input int a1, input int a2, input int a3, input logic [3:0] o);
    mp_accu_init = init; mp_accu_base = bas;
    ea[0] = AW'(a0); ea[1] = AW'(a1); ea[2] = AW'(a2); ea[3] = AW'(a3); eo = o;
  endtask

  task automatic check_reset_outs();
    check("rst_busy", busy, 0);            check("rst_done", done, 0);
    check("rst_mp_angle", mp_angle, 0);    check("rst_mp_line", mp_line_cnt, 0);
    check("rst_valid", addr_valid, 0);     check("rst_addr", addr, 0);
    check("rst_line", addr_line, 0);       check("rst_last", addr_last, 0);
    check("rst_oob", addr_oob, 0);
  endtask

  // One full angle: 2 lines x 4 beats. Beats are checked every valid cycle, so held values are checked too.
  task automatic run(input logic [AL-1:0] ang, input int stall_beat, input bit inj);
    int cyc, beat, stalls, first_v;
    bit dn;
    @(negedge clk); start = 1'b1; angle = ang; addr_ready = 1'b1;
    @(negedge clk); start = 1'b0; angle = 9'h1ff;
    cyc = 1; beat = 0; stalls = 0; first_v = -1; dn = 1'b0;
    while (!dn && cyc < 60) begin
      start = inj && (cyc == 5);
      if (inj) angle = 9'd7;
      if (stall_beat >= 0 && beat == stall_beat && stalls < 3) begin
        addr_ready = 1'b0; stalls++;
      end else addr_ready = 1'b1;
      check("busy", busy, 1);
      check("mp_angle", mp_angle, ang);
      if (addr_valid) begin
        if (first_v < 0) begin first_v = cyc; check("first_beat_cycle", cyc, 3); end
        check("addr", addr, ea[beat % 4]);
        check("oob", addr_oob, eo[beat % 4]);
        check("last", addr_last, (beat % 4) == 3);
        check("line", addr_line, beat / 4);
        if (addr_ready) beat++;
      end
      if (done) begin
        dn = 1'b1;
        check("done_cycle", cyc, 13 + stalls);
        check("beat_count", beat, 8);
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0; addr_ready = 1'b1;
    if (!dn) check("done_timeout", 0, 1);
    check("idle_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    #12;
    check_reset_outs();
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check_reset_outs();

`ifdef NABP_MAPPER_ROUND_EN
    set_exp(20'h00080, 20'h00100, 1, 2, 3, 3, 4'b1000); run(9'd1, -1, 0);
    set_exp(20'h00280, 20'h00100, 3, 3, 3, 3, 4'b1110); run(9'd2, -1, 0);
`else
    set_exp(20'h00080, 20'h00100, 0, 1, 2, 3, 4'b0000); run(9'd1, -1, 0);
    set_exp(20'h00280, 20'h00100, 2, 3, 3, 3, 4'b1100); run(9'd2, -1, 0);
`endif
    set_exp(20'h0027F, 20'h00100, 2, 3, 3, 3, 4'b1100); run(9'd3, -1, 0);
    set_exp(20'h00100, 20'hFFF00, 1, 0, 0, 0, 4'b1100); run(9'd4, -1, 0);
    set_exp(20'h00500, 20'h00100, 3, 3, 3, 3, 4'b1111); run(9'd6, -1, 0);

`ifdef NABP_MAPPER_ROUND_EN
    set_exp(20'h00080, 20'h00100, 1, 2, 3, 3, 4'b1000);
`else
    set_exp(20'h00080, 20'h00100, 0, 1, 2, 3, 4'b0000);
`endif
    run(9'd8, 1, 0);
    run(9'd5, -1, 1);
    run(9'd7, -1, 0);

    // Reset in the middle of MAP.
    @(negedge clk); start = 1'b1; angle = 9'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_in_map", addr_valid, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_outs();
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", done, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_release", busy, 0);
    run(9'd3, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
